// File: rtl/bj_redirect_ctrl_pkg.sv
// bj_redirect_ctrl_pkg: shared PC type, sequencer states and default vectors.
package bj_redirect_ctrl_pkg;
    localparam int CPU_XLEN = 32;
    typedef logic [CPU_XLEN-1:0] cpu_t;
    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;
    localparam cpu_t RESET_PC_DEF = 32'h0000_0000;
    localparam cpu_t TRAP_VEC_DEF = 32'h0000_0100;
endpackage

// File: rtl/bj_redirect_cnt.sv
// bj_redirect_cnt: saturating event counter with increment enable.
module bj_redirect_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bj_redirect_ctrl.sv
// bj_redirect_ctrl: fetch PC sequencer with branch/jump redirect, kill window
// and misaligned-target trap.
module bj_redirect_ctrl
    import bj_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN         = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC     = TRAP_VEC_DEF,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ex_valid,
    input  logic              i_bj_en,
    input  logic [XLEN-1:0]   i_bj_pc,
    input  logic              i_fetch_ready,
    input  logic              i_trap_ack,
    output logic              o_fetch_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_pc_add4,
    output logic              o_flush,
    output logic              o_trap,
    output logic [XLEN-1:0]   o_trap_addr,
    output logic [PERF_W-1:0] o_redirect_cnt
);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [XLEN-1:0] pc_nx, trap_addr_nx;
    logic            redir, inc;

    assign redir         = i_ex_valid & i_bj_en;
    assign o_pc_add4     = o_pc + XLEN'(4);
    assign o_fetch_valid = state == RUN;
    // Kill and trap flags come straight off the state register, so they rise the cycle after redir.
    assign o_flush       = state != RUN;
    assign o_trap        = state == TRAP;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pc_nx        = o_pc;
        trap_addr_nx = o_trap_addr;
        inc          = 1'b0;
        case (state)
            RUN: begin
                if (redir && i_bj_pc[1:0] == 2'b00) begin
                    pc_nx    = i_bj_pc;
                    cnt_nx   = FLUSH_INIT;
                    state_nx = FLUSH;
                    inc      = 1'b1;
                end else if (redir) begin
                    trap_addr_nx = i_bj_pc;
                    state_nx     = TRAP;
                end else if (i_fetch_ready) begin
                    pc_nx = o_pc_add4;
                end
            end
            FLUSH: begin
                cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                state_nx = cnt == 4'd0 ? RUN : FLUSH;
            end
            TRAP: begin
                pc_nx    = i_trap_ack ? TRAP_VEC : o_pc;
                state_nx = i_trap_ack ? RUN : TRAP;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= 4'd0;
            o_pc        <= RESET_PC;
            o_trap_addr <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            o_pc        <= pc_nx;
            o_trap_addr <= trap_addr_nx;
        end

    bj_redirect_cnt #(.W(PERF_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (inc),
        .cnt  (o_redirect_cnt)
    );
endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// tb_bj_redirect_ctrl: vector table with scoreboard queue, plus reset-mid-window sequences.
module tb_bj_redirect_ctrl;
    typedef struct {
        logic        ev, be;
        logic [31:0] bpc;
        logic        fr, ta;
        logic        fv;
        logic [31:0] pc;
        logic        fl, tr;
        logic [31:0] taddr;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } vec_t;

    logic        clk = 0, rst_n = 0;
    logic        ex_valid = 0, bj_en = 0, fetch_ready = 0, trap_ack = 0;
    logic [31:0] bj_pc = 0;
    logic        fetch_valid, flush, trap, fetch_valid2, flush2, trap2;
    logic [31:0] pc, pc_add4, trap_addr, pc2, pc_add4_2, trap_addr2;
    logic [15:0] redirect_cnt;
    logic [1:0]  sat_cnt;
    int          n_vec = 0, n_bad = 0;
    vec_t        tbl[$];
    vec_t        sb[$];

    always #5 clk = ~clk;

    bj_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_ex_valid(ex_valid), .i_bj_en(bj_en), .i_bj_pc(bj_pc),
        .i_fetch_ready(fetch_ready), .i_trap_ack(trap_ack), .o_fetch_valid(fetch_valid),
        .o_pc(pc), .o_pc_add4(pc_add4), .o_flush(flush), .o_trap(trap),
        .o_trap_addr(trap_addr), .o_redirect_cnt(redirect_cnt)
    );

    bj_redirect_ctrl #(.PERF_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_ex_valid(ex_valid), .i_bj_en(bj_en), .i_bj_pc(bj_pc),
        .i_fetch_ready(fetch_ready), .i_trap_ack(trap_ack), .o_fetch_valid(fetch_valid2),
        .o_pc(pc2), .o_pc_add4(pc_add4_2), .o_flush(flush2), .o_trap(trap2),
        .o_trap_addr(trap_addr2), .o_redirect_cnt(sat_cnt)
    );

    function automatic vec_t v(input logic ev, be, input logic [31:0] bpc, input logic fr, ta,
                               input logic fv, input logic [31:0] epc, input logic fl, tr,
                               input logic [31:0] taddr, input logic [15:0] cnt, input logic [1:0] sat);
        vec_t r;
        r.ev = ev; r.be = be; r.bpc = bpc; r.fr = fr; r.ta = ta;
        r.fv = fv; r.pc = epc; r.fl = fl; r.tr = tr; r.taddr = taddr; r.cnt = cnt; r.sat = sat;
        return r;
    endfunction

    task automatic chk(input string nm, input vec_t e);
        n_vec++;
        if (fetch_valid !== e.fv || pc !== e.pc || pc_add4 !== e.pc + 32'd4 || flush !== e.fl ||
            trap !== e.tr || trap_addr !== e.taddr || redirect_cnt !== e.cnt || sat_cnt !== e.sat) begin
            n_bad++;
            $display("FAIL %s: got fv=%0b pc=%h add4=%h fl=%0b tr=%0b ta=%h cnt=%0d sat=%0d, want fv=%0b pc=%h add4=%h fl=%0b tr=%0b ta=%h cnt=%0d sat=%0d",
                     nm, fetch_valid, pc, pc_add4, flush, trap, trap_addr, redirect_cnt, sat_cnt,
                     e.fv, e.pc, e.pc + 32'd4, e.fl, e.tr, e.taddr, e.cnt, e.sat);
        end
    endtask

    task automatic drive(input vec_t e);
        ex_valid = e.ev; bj_en = e.be; bj_pc = e.bpc; fetch_ready = e.fr; trap_ack = e.ta;
    endtask

    initial begin
        //           ev be bpc           fr ta   fv pc            fl tr taddr  cnt sat
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h4,        0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h8,        0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'hC,        0, 0, 32'h0,  0, 0));
        tbl.push_back(v(1, 1, 32'h40,       0, 0,  0, 32'h40,       1, 0, 32'h0,  1, 1));
        tbl.push_back(v(1, 1, 32'h80,       1, 0,  0, 32'h40,       1, 0, 32'h0,  1, 1));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h40,       0, 0, 32'h0,  1, 1));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h44,       0, 0, 32'h0,  1, 1));
        tbl.push_back(v(1, 1, 32'h10,       1, 0,  0, 32'h10,       1, 0, 32'h0,  2, 2));
        tbl.push_back(v(1, 1, 32'h200,      1, 0,  0, 32'h10,       1, 0, 32'h0,  2, 2));
        tbl.push_back(v(0, 0, 32'h0,        0, 0,  1, 32'h10,       0, 0, 32'h0,  2, 2));
        tbl.push_back(v(0, 0, 32'h0,        0, 0,  1, 32'h10,       0, 0, 32'h0,  2, 2));
        tbl.push_back(v(1, 1, 32'h42,       1, 0,  0, 32'h10,       1, 1, 32'h42, 2, 2));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  0, 32'h10,       1, 1, 32'h42, 2, 2));
        tbl.push_back(v(1, 1, 32'h8,        1, 0,  0, 32'h10,       1, 1, 32'h42, 2, 2));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  0, 32'h10,       1, 1, 32'h42, 2, 2));
        tbl.push_back(v(0, 0, 32'h0,        0, 1,  1, 32'h100,      0, 0, 32'h42, 2, 2));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h104,      0, 0, 32'h42, 2, 2));
        tbl.push_back(v(0, 0, 32'h0,        0, 1,  1, 32'h104,      0, 0, 32'h42, 2, 2));
        tbl.push_back(v(0, 1, 32'h300,      1, 0,  1, 32'h108,      0, 0, 32'h42, 2, 2));
        tbl.push_back(v(1, 0, 32'h300,      1, 0,  1, 32'h10C,      0, 0, 32'h42, 2, 2));
        tbl.push_back(v(1, 1, 32'hFFFF_FFFC,0, 0,  0, 32'hFFFF_FFFC,1, 0, 32'h42, 3, 3));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  0, 32'hFFFF_FFFC,1, 0, 32'h42, 3, 3));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'hFFFF_FFFC,0, 0, 32'h42, 3, 3));
        tbl.push_back(v(0, 0, 32'h0,        1, 0,  1, 32'h0,        0, 0, 32'h42, 3, 3));
        tbl.push_back(v(1, 1, 32'h20,       0, 0,  0, 32'h20,       1, 0, 32'h42, 4, 3));
        tbl.push_back(v(0, 0, 32'h0,        0, 0,  0, 32'h20,       1, 0, 32'h42, 4, 3));
        tbl.push_back(v(0, 0, 32'h0,        0, 0,  1, 32'h20,       0, 0, 32'h42, 4, 3));
        tbl.push_back(v(1, 1, 32'h24,       0, 0,  0, 32'h24,       1, 0, 32'h42, 5, 3));

        repeat (2) @(posedge clk);
        #1 chk("reset", v(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0));
        @(negedge clk) rst_n = 1;
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), sb.pop_front());
        end

        // Reset asserted during the first kill-window cycle
        #2 rst_n = 0;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("rst_mid_flush", v(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0));
        @(negedge clk) rst_n = 1;
        fetch_ready = 1;
        @(posedge clk);
        #1 chk("post_rst_fetch", v(0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 32'h0, 0, 0));

        // Reset asserted while a misalign trap is pending
        @(negedge clk) drive(v(1, 1, 32'h43, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 chk("trap_pending", v(0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 32'h43, 0, 0));
        #2 rst_n = 0;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("rst_mid_trap", v(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0));
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 chk("post_rst_idle", v(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
